// File: rtl/imm_read_arbiter.sv
// Round-robin arbiter sharing the immBuffer read ports among issue queues.
// Grants are combinational; the immediate returns through a registered
// response one cycle after the grant.
module imm_read_arbiter #(
    parameter int unsigned REQ_NUM  = 4,
    parameter int unsigned PORT_NUM = 2,
    parameter int unsigned IDX_WID  = 5,
    parameter int unsigned DATA_WID = 20
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_squash_vld,
    input  logic [REQ_NUM-1:0]           i_req_vld,
    input  logic [REQ_NUM*IDX_WID-1:0]   i_req_idx,
    output logic [REQ_NUM-1:0]           o_req_gnt,
    output logic [PORT_NUM*IDX_WID-1:0]  o_read_idx,
    input  logic [PORT_NUM*DATA_WID-1:0] i_read_data,
    output logic [REQ_NUM-1:0]           o_resp_vld,
    output logic [REQ_NUM*DATA_WID-1:0]  o_resp_data,
    output logic [31:0]                  o_conflict_cnt
);

    localparam int unsigned PTR_W = $clog2(REQ_NUM);

    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    ptr_next;
    logic [DATA_WID-1:0] sel_data [REQ_NUM];
    logic                conflict;
    int unsigned         scan_r;
    int unsigned         gnt_cnt;
    int unsigned         last_gnt;

    // Scan from ptr, grant the first PORT_NUM valid requesters and route each
    // to the next free read port; also capture the data each grant will return.
    always_comb begin
        o_req_gnt  = '0;
        o_read_idx = '0;
        ptr_next   = ptr;
        scan_r     = 0;
        gnt_cnt    = 0;
        last_gnt   = 0;
        for (int unsigned r = 0; r < REQ_NUM; r++) begin
            sel_data[r] = '0;
        end
        for (int unsigned s = 0; s < REQ_NUM; s++) begin
            scan_r = (int'(ptr) + s) % REQ_NUM;
            if (!i_squash_vld && i_req_vld[scan_r] && gnt_cnt < PORT_NUM) begin
                o_req_gnt[scan_r] = 1'b1;
                o_read_idx[gnt_cnt*IDX_WID +: IDX_WID] = i_req_idx[scan_r*IDX_WID +: IDX_WID];
                sel_data[scan_r] = i_read_data[gnt_cnt*DATA_WID +: DATA_WID];
                gnt_cnt  = gnt_cnt + 1;
                last_gnt = scan_r;
            end
        end
        if (gnt_cnt != 0) begin
            ptr_next = PTR_W'((last_gnt + 1) % REQ_NUM);
        end
    end

    // A cycle is a conflict when valid requests exceed the ports, or any
    // request is present while squashed (none can be granted then).
    always_comb begin
        conflict = ($countones(i_req_vld) > int'(PORT_NUM)) ||
                   (i_squash_vld && (|i_req_vld));
    end

    // Round-robin pointer; squash suppresses the update via the zero grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

    // Registered response: valid follows the grant, data holds when not granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_resp_vld  <= '0;
            o_resp_data <= '0;
        end else begin
            o_resp_vld <= o_req_gnt;
            for (int unsigned r = 0; r < REQ_NUM; r++) begin
                if (o_req_gnt[r]) begin
                    o_resp_data[r*DATA_WID +: DATA_WID] <= sel_data[r];
                end
            end
        end
    end

    // Saturating conflict counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_conflict_cnt <= '0;
        end else if (conflict && o_conflict_cnt != '1) begin
            o_conflict_cnt <= o_conflict_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_imm_read_arbiter.sv
// Directed self-checking bench for imm_read_arbiter: a 4-requester/2-port
// instance and a 3-requester/1-port instance sharing clock and reset.
module tb_imm_read_arbiter;

    logic        clk;
    logic        rst;
    logic        squash;

    // 4 requesters, 2 ports
    logic [3:0]  vld;
    logic [19:0] idx;
    logic [3:0]  gnt;
    logic [9:0]  ridx;
    logic [39:0] rdata;
    logic [3:0]  rvld;
    logic [79:0] rdat;
    logic [31:0] ccnt;

    // 3 requesters, 1 port
    logic [2:0]  vld1;
    logic [14:0] idx1;
    logic [2:0]  gnt1;
    logic [4:0]  ridx1;
    logic [19:0] rdata1;
    logic [2:0]  rvld1;
    logic [59:0] rdat1;
    logic [31:0] ccnt1;

    logic [19:0] mem [32];

    int n_checks = 0;
    int n_fail   = 0;

    imm_read_arbiter #(.REQ_NUM(4), .PORT_NUM(2), .IDX_WID(5), .DATA_WID(20)) dut (
        .clk(clk), .rst(rst), .i_squash_vld(squash),
        .i_req_vld(vld), .i_req_idx(idx), .o_req_gnt(gnt), .o_read_idx(ridx),
        .i_read_data(rdata), .o_resp_vld(rvld), .o_resp_data(rdat),
        .o_conflict_cnt(ccnt)
    );

    imm_read_arbiter #(.REQ_NUM(3), .PORT_NUM(1), .IDX_WID(5), .DATA_WID(20)) dut1 (
        .clk(clk), .rst(rst), .i_squash_vld(squash),
        .i_req_vld(vld1), .i_req_idx(idx1), .o_req_gnt(gnt1), .o_read_idx(ridx1),
        .i_read_data(rdata1), .o_resp_vld(rvld1), .o_resp_data(rdat1),
        .o_conflict_cnt(ccnt1)
    );

    // Combinational immBuffer model
    always_comb begin
        rdata  = {mem[ridx[9:5]], mem[ridx[4:0]]};
        rdata1 = mem[ridx1];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 20'h0;
        mem[3]  = 20'h00AAA;
        mem[5]  = 20'h00CCC;
        mem[7]  = 20'h00BBB;
        mem[9]  = 20'h00DDD;
        mem[10] = 20'h11111;
        mem[11] = 20'h22222;
        mem[12] = 20'h33333;

        // req0 idx 3, req1 idx 5, req2 idx 7, req3 idx 9
        idx    = {5'd9, 5'd7, 5'd5, 5'd3};
        idx1   = {5'd12, 5'd11, 5'd10};
        vld    = 4'b1111;
        vld1   = 3'b000;
        squash = 1'b0;
        rst    = 1'b1;

        // Reset held 2 cycles with all requests valid
        step();
        step();
        rst = 1'b0;
        #1;
        check("reset_resp_vld", 80'(rvld), 80'(4'b0000));
        check("reset_cnt", 80'(ccnt), 80'd0);
        check("reset_resp_data", rdat, 80'd0);
        check("sp_reset_idle_gnt", 80'(gnt1), 80'(3'b000));
        check("sp_reset_idle_ridx", 80'(ridx1), 80'd0);

        // Rotation: all four valid for 4 cycles
        check("rot1_gnt", 80'(gnt), 80'(4'b0011));
        check("rot1_ridx", 80'(ridx), 80'({5'd5, 5'd3}));
        step();
        check("rot1_resp_vld", 80'(rvld), 80'(4'b0011));
        check("rot1_resp_d0", 80'(rdat[19:0]), 80'(20'h00AAA));
        check("rot1_resp_d1", 80'(rdat[39:20]), 80'(20'h00CCC));
        check("rot2_gnt", 80'(gnt), 80'(4'b1100));
        check("rot2_ridx", 80'(ridx), 80'({5'd9, 5'd7}));
        step();
        check("rot2_resp_vld", 80'(rvld), 80'(4'b1100));
        check("rot2_resp_d2", 80'(rdat[59:40]), 80'(20'h00BBB));
        check("rot2_resp_d3", 80'(rdat[79:60]), 80'(20'h00DDD));
        check("rot3_gnt", 80'(gnt), 80'(4'b0011));
        step();
        check("rot4_gnt", 80'(gnt), 80'(4'b1100));
        step();
        check("rot_cnt", 80'(ccnt), 80'd4);

        // Two requesters: 0 and 2 (ptr is 0)
        vld = 4'b0101;
        #1;
        check("two_gnt", 80'(gnt), 80'(4'b0101));
        check("two_ridx", 80'(ridx), 80'({5'd7, 5'd3}));
        step();
        check("two_resp_vld", 80'(rvld), 80'(4'b0101));
        check("two_resp_d0", 80'(rdat[19:0]), 80'(20'h00AAA));
        check("two_resp_d2", 80'(rdat[59:40]), 80'(20'h00BBB));
        check("two_cnt", 80'(ccnt), 80'd4);

        // Wrap: ptr is 3, requesters 3 and 0
        vld = 4'b1001;
        #1;
        check("wrap_gnt", 80'(gnt), 80'(4'b1001));
        check("wrap_ridx", 80'(ridx), 80'({5'd3, 5'd9}));
        step();
        check("wrap_resp_vld", 80'(rvld), 80'(4'b1001));
        check("wrap_resp_d3", 80'(rdat[79:60]), 80'(20'h00DDD));
        // ptr now 1: all valid grants 1 and 2
        vld = 4'b1111;
        #1;
        check("wrap_ptr1_gnt", 80'(gnt), 80'(4'b0110));
        check("wrap_ptr1_ridx", 80'(ridx), 80'({5'd7, 5'd5}));
        step();
        check("wrap_ptr1_cnt", 80'(ccnt), 80'd5);

        // Squash with all valid (ptr is 3)
        squash = 1'b1;
        #1;
        check("sq_gnt", 80'(gnt), 80'(4'b0000));
        check("sq_ridx", 80'(ridx), 80'd0);
        check("sq_visible_resp", 80'(rvld), 80'(4'b0110));
        step();
        squash = 1'b0;
        #1;
        check("sq_resp_vld", 80'(rvld), 80'(4'b0000));
        check("sq_cnt", 80'(ccnt), 80'd6);
        check("sq_hold_d2", 80'(rdat[59:40]), 80'(20'h00BBB));
        check("sq_ptr_gnt", 80'(gnt), 80'(4'b1001));
        step();
        check("post_sq_cnt", 80'(ccnt), 80'd7);

        // Idle: no requests
        vld = 4'b0000;
        #1;
        check("idle_gnt", 80'(gnt), 80'(4'b0000));
        check("idle_ridx", 80'(ridx), 80'd0);
        step();
        check("idle_resp_vld", 80'(rvld), 80'(4'b0000));
        check("idle_cnt", 80'(ccnt), 80'd7);

        // Reset mid-operation (ptr is 1): the launched grant is dropped
        vld = 4'b1111;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("midrst_resp_vld", 80'(rvld), 80'(4'b0000));
        check("midrst_cnt", 80'(ccnt), 80'd0);
        check("midrst_gnt", 80'(gnt), 80'(4'b0011));
        vld = 4'b0000;

        // Single-port instance: grants rotate 0,1,2,0
        vld1 = 3'b111;
        #1;
        check("sp_g0", 80'(gnt1), 80'(3'b001));
        check("sp_ridx0", 80'(ridx1), 80'd10);
        step();
        check("sp_resp0_vld", 80'(rvld1), 80'(3'b001));
        check("sp_resp0_d", 80'(rdat1[19:0]), 80'(20'h11111));
        check("sp_g1", 80'(gnt1), 80'(3'b010));
        check("sp_ridx1", 80'(ridx1), 80'd11);
        step();
        check("sp_resp1_vld", 80'(rvld1), 80'(3'b010));
        check("sp_resp1_d", 80'(rdat1[39:20]), 80'(20'h22222));
        check("sp_g2", 80'(gnt1), 80'(3'b100));
        step();
        check("sp_resp2_vld", 80'(rvld1), 80'(3'b100));
        check("sp_resp2_d", 80'(rdat1[59:40]), 80'(20'h33333));
        check("sp_g3", 80'(gnt1), 80'(3'b001));
        check("sp_cnt", 80'(ccnt1), 80'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_read_arbiter.md
# imm_read_arbiter

Round-robin arbiter that shares the immediate-buffer read ports among the issue queues. Each issue queue raises a read request carrying an irob index. The arbiter grants up to PORT_NUM requesters per cycle, drives the immBuffer read ports, and returns the immediate to each granted requester one cycle later through a registered response. It sits between the issue queues and the dispatch-stage immBuffer read interface.

## Interface

**Parameters**
- REQ_NUM, 4, number of requesters (issue queues); ≥ 2.
- PORT_NUM, 2, immBuffer read ports; 1 ≤ PORT_NUM ≤ REQ_NUM.
- IDX_WID, 5, irob index width.
- DATA_WID, 20, immediate width.

**Ports**
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- i_squash_vld  in  1  pipeline flush.
- i_req_vld  in  REQ_NUM  per-requester read request.
- i_req_idx  in  REQ_NUM*IDX_WID  irob index; slice r belongs to requester r.
- o_req_gnt  out  REQ_NUM  combinational grant, same cycle as the request.
- o_read_idx  out  PORT_NUM*IDX_WID  index to immBuffer read port p.
- i_read_data  in  PORT_NUM*DATA_WID  combinational immBuffer read data.
- o_resp_vld  out  REQ_NUM  registered response valid.
- o_resp_data  out  REQ_NUM*DATA_WID  registered immediate per requester.
- o_conflict_cnt  out  32  saturating count of cycles in which at least one valid request was not granted.

## Operation

**Round-robin pointer**
- State ptr, range 0..REQ_NUM-1; resets to 0.
- Scan order each cycle: ptr, ptr+1, …, ptr+REQ_NUM-1, all mod REQ_NUM.

**Granting**
- The first PORT_NUM valid requesters in scan order are granted.
- The k-th granted requester (k = 0..PORT_NUM-1) is assigned read port k; o_read_idx[k] = its i_req_idx.
- Unused ports drive index 0. Their data is ignored.

**Pointer update**
- If any grant occurs, ptr <= (index of last granted requester + 1) mod REQ_NUM.
- Otherwise ptr is unchanged.

**Handshake**
- A requester holds i_req_vld and i_req_idx stable until it sees o_req_gnt.
- A granted requester may present a new request the following cycle.

**Response**
- At the edge ending the grant cycle: o_resp_vld[r] <= o_req_gnt[r], and o_resp_data[r] <= i_read_data of r's assigned port.
- For ungranted r, o_resp_vld[r] <= 0 and o_resp_data[r] holds its value.

**Squash**
- While i_squash_vld = 1: o_req_gnt = 0 and the ptr update is suppressed.
- At that edge o_resp_vld <= 0.
- A response already visible in the squash cycle is not masked; consumers are flushed by the same squash.

**Conflict counter**
- Increments by 1 when |i_req_vld and the valid requesters outnumber the grants, i.e. popcount(i_req_vld) > PORT_NUM, or any valid request during squash.
- Saturates at 2^32-1.

**Reset values**
- ptr = 0, o_resp_vld = 0, o_resp_data = 0, o_conflict_cnt = 0.
- With i_req_vld = 0: o_req_gnt = 0 and o_read_idx = 0.
- rst takes priority over i_squash_vld.

## Timing
- Request to grant: 0 cycles (combinational).
- Grant to response: exactly 1 cycle.
- Throughput: PORT_NUM reads per cycle.
- Fairness: any continuously requesting requester is granted within ceil(REQ_NUM/PORT_NUM) cycles.
- Pointer wrap: when the last grant is requester REQ_NUM-1, the next ptr is 0.
- immBuffer read is combinational: i_read_data[p] must be valid in the same cycle as o_read_idx[p].
- A grant and a clear of the same irob entry in one cycle returns the pre-clear data.
- Reset mid-operation: responses launched by the cycle before reset are dropped, and o_resp_vld is 0 in the cycle after the reset edge.

## Test plan
- **Reset.** Assert rst for 2 cycles with all i_req_vld = 1 → o_resp_vld = 0 and o_conflict_cnt = 0 after release; the first grant goes to requesters 0 and 1.
- **Two requesters.** i_req_vld = 4'b0101, idx2 = 7, idx0 = 3, immBuffer[3] = 0x00AAA, immBuffer[7] = 0x00BBB:
  - gnt = 0101, port0 idx 3, port1 idx 7.
  - Next cycle: resp_vld = 0101, resp_data[0] = 0x00AAA, resp_data[2] = 0x00BBB.
  - ptr becomes 3.
- **Rotation.** All four requesters held valid for 4 cycles → gnt sequence 0011, 1100, 0011, 1100; o_conflict_cnt = 4.
- **Wrap.** ptr = 3, i_req_vld = 1001 → gnt = 1001 with requester 3 on port 0 and requester 0 on port 1; ptr becomes 1.
- **Squash.** i_req_vld = 1111 with i_squash_vld = 1 for one cycle → gnt = 0000, next-cycle resp_vld = 0000, ptr unchanged, o_conflict_cnt increments by 1.
- **Single port.** PORT_NUM = 1, REQ_NUM = 3, all valid → grants rotate 0, 1, 2, 0; each response appears exactly 1 cycle after its grant.
